// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator.
//
// A clock divider produces a one-clk pixel enable every CLK_DIV system
// clocks. The horizontal and vertical counters advance on that enable.
// Sync, visible-area and frame-start decodes are all registered on the same
// edge as the counters, so they are never skewed from hCount/vCount.
//
// Ports:
//   clk         in   system clock (100 MHz)
//   reset       in   synchronous, active-high reset
//   pix_en      out  high for one clk at the end of each pixel period
//   hCount      out  current pixel column, 0..H_TOTAL-1
//   vCount      out  current line, 0..V_TOTAL-1
//   video_on    out  high inside the visible area
//   hSync       out  horizontal sync, SYNC_ACTIVE level during the pulse
//   vSync       out  vertical sync, SYNC_ACTIVE level during the pulse
//   frame_start out  one-clk pulse on the last clk of the final pixel of a frame
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       video_on,
  output logic       hSync,
  output logic       vSync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Window bounds are compared in 11 bits so a bound of exactly 1024 works.
  localparam logic [10:0] H_VIS_END   = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END  = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END   = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END  = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [4:0]  DIV_LAST    = 5'(CLK_DIV - 1);
  localparam logic        PIX_EN_RST  = (CLK_DIV == 1) ? 1'b1 : 1'b0;

  // Elaboration-time parameter legality.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end

  logic [4:0] div_q, div_d;
  logic       pix_en_q, pix_en_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       video_on_q, video_on_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;

  // Next-state for divider, counters and all decodes.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? 5'd0 : div_q + 5'd1;
    // pix_en register mirrors (div == CLK_DIV-1), so decode it from div_d.
    pix_en_d = (div_d == DIV_LAST);

    h_d = h_q;
    v_d = v_q;
    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      h_d = h_q;
    end

    // Decodes use the next count values so they line up with the counters.
    video_on_d = ({1'b0, h_d} < H_VIS_END) && ({1'b0, v_d} < V_VIS_END);
    hsync_d    = (({1'b0, h_d} >= H_SYNC_BEG) && ({1'b0, h_d} < H_SYNC_END))
                 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d    = (({1'b0, v_d} >= V_SYNC_BEG) && ({1'b0, v_d} < V_SYNC_END))
                 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_start_d = pix_en_d && (h_d == H_LAST) && (v_d == V_LAST);
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= 5'd0;
      pix_en_q      <= PIX_EN_RST;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      video_on_q    <= 1'b1;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      h_q           <= h_d;
      v_q           <= v_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hCount      = h_q;
  assign vCount      = v_q;
  assign video_on    = video_on_q;
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
- Produces hSync/vSync, a pixel-rate enable, pixel coordinates and a visible-area flag.
- Sits directly upstream of vga_digit_display, which consumes hCount/vCount/video_on to decide R/G/B per pixel and forwards hSync/vSync to the pins.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); legal range 1..16
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hSync/vSync during the sync pulse (0 = active-low)

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- pix_en  output  1  high for one clk at the end of each pixel period
- hCount  output  10  current pixel column, 0..H_TOTAL-1
- vCount  output  10  current line, 0..V_TOTAL-1
- video_on  output  1  high when hCount < H_VISIBLE and vCount < V_VISIBLE
- hSync  output  1  horizontal sync
- vSync  output  1  vertical sync
- frame_start  output  1  one-clk pulse on the last clk of the final pixel of a frame

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both must be <= 1024 (elaboration-time assertion).
- Clock and reset:
  - One clock, clk; every register updates on its rising edge.
  - reset is synchronous and active-high, and has priority over all other logic.
- Reset values, held while reset = 1 and present in the first cycle after release:
  - div = 0, hCount = 0, vCount = 0, pix_en = 0 (1 if CLK_DIV = 1)
  - video_on = 1, hSync = vSync = ~SYNC_ACTIVE, frame_start = 0
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div == CLK_DIV-1), decoded from the div register.
  - First pix_en occurs in cycle CLK_DIV-1 after reset release (cycle 3 at default).
  - CLK_DIV = 1: pix_en is constantly 1 outside reset.
- Horizontal counter:
  - On an edge closing a cycle with pix_en = 1: hCount increments, or wraps to 0 from H_TOTAL-1.
  - Each hCount value is held for exactly CLK_DIV clks.
- Vertical counter:
  - Increments only when hCount wraps (pix_en = 1 and hCount == H_TOTAL-1).
  - Wraps to 0 from V_TOTAL-1 in the same edge that hCount wraps.
- Decode:
  - Registered, updated on the same edge as the counters and computed from the next count values, so decode is never skewed from hCount/vCount.
  - hSync = SYNC_ACTIVE iff H_VISIBLE+H_FP <= hCount < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vSync = SYNC_ACTIVE iff V_VISIBLE+V_FP <= vCount < V_VISIBLE+V_FP+V_SYNC (490..491).
  - video_on = hCount < H_VISIBLE && vCount < V_VISIBLE.
- frame_start = pix_en && hCount == H_TOTAL-1 && vCount == V_TOTAL-1, decoded from registers. It is exactly one clk wide, once per frame.
- Periods:
  - Line = H_TOTAL*CLK_DIV clks (3200).
  - Frame = H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000).
- Reset mid-frame: the next edge forces all state to reset values. No partial-line completion, and no spurious frame_start.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. There are no other inputs, so there are no simultaneous-event cases beyond the h/v wrap described above.

Test Plan:
- Reset then release, count clks: pix_en first high in cycle 3 after release, then every 4th clk; hCount = 1 from cycle 4, hCount = 2 from cycle 8.
- Run one line: hSync low exactly for hCount 656..751 (384 clks); video_on falls at hCount = 640; hCount wraps 799 -> 0 and vCount goes 0 -> 1 on the same edge, 3200 clks after release.
- Run a full frame: vSync low for vCount 490..491 (6400 clks); video_on = 0 for all vCount >= 480; frame_start pulses once, 1 clk wide, at clk 1,679,999 after release; the next frame_start comes 1,680,000 clks later.
- Assert reset for 1 clk mid-line (hCount = 700, vCount = 300, inside hSync): the next cycle shows hCount = 0, vCount = 0, hSync = 1, vSync = 1, video_on = 1, frame_start = 0; timing then restarts exactly as in scenario 1.
- Parameterise CLK_DIV = 1: pix_en constantly 1; the line period is 800 clks and the frame period is 420,000 clks; sync windows are unchanged in count values.
- Parameterise SYNC_ACTIVE = 1: hSync/vSync are inverted relative to scenario 2/3, the reset level is 0, and all windows are unchanged.
